md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Sequencing controller for the shared multiply/divide resource fed from the E stage (start, MDop, MDsign, HIWrite, immWrite, HIRead).
- Accepts one MD operation at a time and runs a multi-cycle busy counter.
- Owns the HI/LO registers and serves MTHI/MTLO writes and MFHI/MFLO reads.
- Raises a stall request to the hazard unit when a D-stage MD-class instruction would collide with a busy or starting unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MSUB when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- startE  input  1  E-stage MD operation start (one-cycle pulse per instruction).
- MDopE  input  2  00 MULT, 01 DIV, 10 MADD, 11 MSUB.
- MDsignE  input  1  1 = signed operands, 0 = unsigned.
- opA  input  32  rs operand (forwarded value).
- opB  input  32  rt operand (forwarded value).
- immWriteE  input  1  MTHI/MTLO write request.
- HIWriteE  input  1  1 = target HI, 0 = target LO (MT write); 1 = read HI, 0 = read LO (hl_out).
- mt_data  input  32  MTHI/MTLO data.
- cancel  input  1  exception/flush response this cycle; suppresses E-stage start and MT write.
- md_use_d  input  1  instruction in D is MD-class (mult/div/mt/mf).
- hl_out  output  32  HI when HIWriteE=1 else LO (combinational from registers).
- busy  output  1  unit running.
- stall_md  output  1  stall request to the hazard unit.

Behaviour:
- States: IDLE, RUN. Reset → IDLE, HI=0, LO=0, counter=0, busy=0, stall_md=0.
- Reset mid-operation: abandons the operation; same reset values apply; the pending result is discarded.
- Accept condition: state IDLE, startE=1, cancel=0, and a legal op.
  - Latches the op and computes the result into pending registers.
  - Loads counter with N (MULT_CYCLES or DIV_CYCLES); → RUN.
- Latency:
  - Start accepted in cycle t → busy=1 in cycles t+1..t+N.
  - HI/LO hold the new value from cycle t+N+1; busy=0 in t+N+1 → IDLE.
- RUN: counter decrements each cycle; HI/LO are written on the edge that ends the cycle where counter==1.
- MULT: 64-bit product of 32x32 operands, sign-extended or zero-extended per MDsignE. HI = product[63:32], LO = product[31:0].
- DIV: LO = quotient, HI = remainder; truncation toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed → LO=0x80000000, HI=0.
  - Divide by zero: HI/LO unchanged; full DIV_CYCLES busy still applies.
- startE while RUN: ignored; HI/LO and counter unaffected.
- MT write (immWriteE=1, cancel=0, IDLE): writes mt_data to HI or LO next edge.
  - Ignored while RUN; the hazard unit guarantees this does not occur.
- MT write and startE in the same cycle: start wins; the MT write is dropped.
- cancel=1: blocks only the E-stage start/MT write of that cycle; a RUN already in progress completes.
- stall_md = md_use_d & (busy | (startE & ~cancel)).
- hl_out reads the committed registers; the pending result is never forwarded.

Optional Feature:
- Macro MD_SCHED_MADD_EN.
  - Defined: MDopE=10 computes {HI,LO} += product; MDopE=11 computes {HI,LO} -= product. Both use the 64-bit wrap-around of the HI/LO at accept time, with MULT_CYCLES latency.
  - Undefined: MDopE=10/11 are illegal. startE is ignored (no busy, no HI/LO change) and stall_md ignores that start.

Test Plan:
- Signed MULT opA=0xFFFFFFFD, opB=5, start at t → busy high t+1..t+5; from t+6 HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Unsigned DIV opA=7, opB=2 → busy for 10 cycles; then LO=3, HI=1.
- Signed DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. Separately, DIV by 0 with HI=0x11, LO=0x22 → both unchanged after 10 cycles.
- MULT started, md_use_d=1 for 3 cycles → stall_md=1 in the start cycle and every busy cycle, 0 after completion. A second startE during RUN → no effect.
- startE=1 with cancel=1 → busy stays 0, HI/LO unchanged. MTHI 0xDEADBEEF with cancel=0 → next cycle hl_out (HIWriteE=1) = 0xDEADBEEF.
- reset asserted at busy cycle 3 of a DIV → next cycle busy=0, HI=LO=0; a following MULT 3x4 yields LO=12, HI=0.

Source files
------------

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide sequencer owning HI/LO, busy counter and MD stall request
// Optional MADD/MSUB accumulate ops are built only when MD_SCHED_MADD_EN is defined.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startE,
  input  logic [1:0]  MDopE,
  input  logic        MDsignE,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        immWriteE,
  input  logic        HIWriteE,
  input  logic [31:0] mt_data,
  input  logic        cancel,
  input  logic        md_use_d,
  output logic [31:0] hl_out,
  output logic        busy,
  output logic        stall_md
);

  typedef enum logic {IDLE, RUN} stateT;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  stateT       state;
  logic [3:0]  count;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pendHi;
  logic [31:0] pendLo;
  logic        pendWrite;

  logic        opLegal;
  logic        isDiv;
  logic        accept;
  logic        mtWrite;
  logic [63:0] aExt;
  logic [63:0] bExt;
  logic [63:0] product;
  logic [63:0] mulResult;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] quotMag;
  logic [31:0] remMag;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        negQuot;
  logic        negRem;
  logic [31:0] nextHi;
  logic [31:0] nextLo;
  logic        nextWrite;

  always_comb begin
`ifdef MD_SCHED_MADD_EN
    opLegal = 1'b1;
`else
    opLegal = ~MDopE[1];
`endif
    isDiv   = (MDopE == 2'b01);
    accept  = (state == IDLE) & startE & ~cancel & opLegal;
    mtWrite = (state == IDLE) & immWriteE & ~cancel & ~accept;
  end

  // Full 64-bit product of the extended operands gives the correct signed or unsigned result mod 2^64.
  always_comb begin
    aExt    = MDsignE ? {{32{opA[31]}}, opA} : {32'h0, opA};
    bExt    = MDsignE ? {{32{opB[31]}}, opB} : {32'h0, opB};
    product = aExt * bExt;
`ifdef MD_SCHED_MADD_EN
    case (MDopE)
      2'b10:   mulResult = {hi, lo} + product;
      2'b11:   mulResult = {hi, lo} - product;
      default: mulResult = product;
    endcase
`else
    mulResult = product;
`endif
  end

  // Magnitude division avoids the signed overflow case; 0x80000000 stays representable unsigned.
  always_comb begin
    negQuot   = MDsignE & (opA[31] ^ opB[31]);
    negRem    = MDsignE & opA[31];
    absA      = (MDsignE & opA[31]) ? (32'h0 - opA) : opA;
    absB      = (MDsignE & opB[31]) ? (32'h0 - opB) : opB;
    quotMag   = (absB == 32'h0) ? 32'h0 : (absA / absB);
    remMag    = (absB == 32'h0) ? 32'h0 : (absA % absB);
    quotient  = negQuot ? (32'h0 - quotMag) : quotMag;
    remainder = negRem ? (32'h0 - remMag) : remMag;
  end

  always_comb begin
    if (isDiv) begin
      nextHi    = remainder;
      nextLo    = quotient;
      nextWrite = (opB != 32'h0);
    end else begin
      nextHi    = mulResult[63:32];
      nextLo    = mulResult[31:0];
      nextWrite = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      busy      <= 1'b0;
      hi        <= 32'h0;
      lo        <= 32'h0;
      pendHi    <= 32'h0;
      pendLo    <= 32'h0;
      pendWrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pendHi    <= nextHi;
            pendLo    <= nextLo;
            pendWrite <= nextWrite;
            count     <= isDiv ? DIV_LOAD : MULT_LOAD;
            busy      <= 1'b1;
            state     <= RUN;
          end else if (mtWrite) begin
            if (HIWriteE) hi <= mt_data;
            else          lo <= mt_data;
          end
        end
        RUN: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (pendWrite) begin
              hi <= pendHi;
              lo <= pendLo;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hl_out   = HIWriteE ? hi : lo;
  assign stall_md = md_use_d & (busy | (startE & ~cancel & opLegal));

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed plus randomized check of md_sched against a behavioural model
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, startE, MDsignE, immWriteE, HIWriteE, cancel, md_use_d;
  logic [1:0]  MDopE;
  logic [31:0] opA, opB, mt_data;
  logic [31:0] hl_out;
  logic        busy, stall_md;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .startE(startE), .MDopE(MDopE), .MDsignE(MDsignE),
    .opA(opA), .opB(opB), .immWriteE(immWriteE), .HIWriteE(HIWriteE), .mt_data(mt_data),
    .cancel(cancel), .md_use_d(md_use_d), .hl_out(hl_out), .busy(busy), .stall_md(stall_md)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] mHi, mLo, mPendHi, mPendLo;
  logic        mPendValid;
  int          mLeft;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legalOp(input logic [1:0] op);
`ifdef MD_SCHED_MADD_EN
    return 1'b1;
`else
    return !op[1];
`endif
  endfunction

  task automatic modelEdge();
    longint      sa, sb;
    logic [63:0] acc;
    if (reset) begin
      mHi = 0; mLo = 0; mLeft = 0; mPendValid = 0;
      return;
    end
    if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0 && mPendValid) begin
        mHi = mPendHi;
        mLo = mPendLo;
      end
    end else if (startE && !cancel && legalOp(MDopE)) begin
      sa = MDsignE ? longint'($signed(opA)) : longint'({32'h0, opA});
      sb = MDsignE ? longint'($signed(opB)) : longint'({32'h0, opB});
      mPendValid = 1;
      if (MDopE == 2'b01) begin
        mLeft = DIV_N;
        if (opB == 0) mPendValid = 0;
        else begin
          mPendLo = 32'(sa / sb);
          mPendHi = 32'(sa % sb);
        end
      end else begin
        mLeft = MULT_N;
        acc = {mHi, mLo};
        if (MDopE == 2'b10)      acc = acc + 64'(sa * sb);
        else if (MDopE == 2'b11) acc = acc - 64'(sa * sb);
        else                     acc = 64'(sa * sb);
        mPendHi = acc[63:32];
        mPendLo = acc[31:0];
      end
    end else if (immWriteE && !cancel) begin
      if (HIWriteE) mHi = mt_data;
      else          mLo = mt_data;
    end
  endtask

  task automatic tick();
    logic expStall;
    @(negedge clk);
    expStall = md_use_d & ((mLeft > 0) | (startE & ~cancel & legalOp(MDopE)));
    check("busy", 32'(busy), 32'(mLeft > 0));
    check("hl_out", hl_out, HIWriteE ? mHi : mLo);
    check("stall_md", 32'(stall_md), 32'(expStall));
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idleInputs();
    reset = 0; startE = 0; MDopE = 0; MDsignE = 0; opA = 0; opB = 0;
    immWriteE = 0; HIWriteE = 0; mt_data = 0; cancel = 0; md_use_d = 0;
  endtask

  task automatic startOp(input logic [1:0] op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    MDopE = op; MDsignE = sgn; opA = a; opB = b; startE = 1;
    tick();
    startE = 0;
  endtask

  task automatic mtWrite(input logic toHi, input logic [31:0] d);
    immWriteE = 1; HIWriteE = toHi; mt_data = d;
    tick();
    immWriteE = 0;
  endtask

  task automatic readBoth(input string tag, input logic [31:0] eHi, input logic [31:0] eLo);
    HIWriteE = 1; #1;
    check({tag, "_hi"}, hl_out, eHi);
    HIWriteE = 0; #1;
    check({tag, "_lo"}, hl_out, eLo);
  endtask

  initial begin
    idleInputs();
    reset = 1;
    mHi = 0; mLo = 0; mLeft = 0; mPendValid = 0; mPendHi = 0; mPendLo = 0;
    @(posedge clk); modelEdge(); #1;
    tick();
    reset = 0;
    tick();
    readBoth("reset", 32'h0, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // Signed MULT -3*5 with a D-stage MD instruction waiting and a redundant start mid-run
    md_use_d = 1;
    startOp(2'b00, 1, 32'hFFFFFFFD, 32'd5);
    tick(); tick();
    md_use_d = 0;
    startOp(2'b01, 0, 32'd100, 32'd7);
    repeat (3) tick();
    readBoth("mult_s", 32'hFFFFFFFF, 32'hFFFFFFF1);

    startOp(2'b01, 0, 32'd7, 32'd2);
    repeat (DIV_N) tick();
    readBoth("divu", 32'd1, 32'd3);

    startOp(2'b01, 1, 32'h80000000, 32'hFFFFFFFF);
    repeat (DIV_N) tick();
    readBoth("div_ovf", 32'h0, 32'h80000000);

    mtWrite(1, 32'h11);
    mtWrite(0, 32'h22);
    startOp(2'b01, 1, 32'd1234, 32'd0);
    repeat (DIV_N) tick();
    readBoth("div0", 32'h11, 32'h22);

    cancel = 1;
    startOp(2'b00, 1, 32'd9, 32'd9);
    cancel = 0;
    check("cancel_busy", 32'(busy), 32'h0);
    readBoth("cancel", 32'h11, 32'h22);

    startOp(2'b10, 0, 32'd2, 32'd3);
    repeat (MULT_N) tick();

    mtWrite(1, 32'hDEADBEEF);
    HIWriteE = 1; #1;
    check("mthi", hl_out, 32'hDEADBEEF);

    startOp(2'b01, 0, 32'd50, 32'd3);
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    check("rst_mid_busy", 32'(busy), 32'h0);
    readBoth("rst_mid", 32'h0, 32'h0);
    startOp(2'b00, 0, 32'd3, 32'd4);
    repeat (MULT_N) tick();
    readBoth("mult_34", 32'h0, 32'd12);

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      startE    = ($urandom_range(0, 3) == 0);
      MDopE     = 2'($urandom_range(0, 3));
      MDsignE   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       opA = 32'h80000000;
        1:       opA = 32'hFFFFFFFF;
        default: opA = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       opB = 32'h0;
        1:       opB = 32'hFFFFFFFF;
        2:       opB = 32'($urandom_range(1, 9));
        default: opB = $urandom;
      endcase
      immWriteE = ($urandom_range(0, 4) == 0);
      HIWriteE  = 1'($urandom_range(0, 1));
      mt_data   = $urandom;
      cancel    = ($urandom_range(0, 7) == 0);
      md_use_d  = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
